// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory fetch unit: fault codes,
// controller state encoding and the NOP word returned on any fault.
package instr_mem_pkg;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;
    localparam logic [1:0] FAULT_PARITY   = 2'b11;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Fetch handshake, flush and loader signals between the IF stage and the instruction memory.
// The master side is the PC/IF stage and loader; the slave side is instr_mem_fetch.
interface instr_mem_fetch_if #(
    parameter int ADDR_W     = 14,
    parameter int WORD_BYTES = 4,
    parameter int PC_W       = 32
);

    logic                    req_valid;
    logic                    req_ready;
    logic [PC_W-1:0]         req_pc;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [8*WORD_BYTES-1:0] resp_instr;
    logic [PC_W-1:0]         resp_pc;
    logic [1:0]              resp_fault;
    logic                    flush;
    logic                    ld_en;
    logic [ADDR_W-1:0]       ld_addr;
    logic [7:0]              ld_data;
    logic                    busy;

    modport master (
        output req_valid, req_pc, resp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_instr, resp_pc, resp_fault, busy
    );

    modport slave (
        input  req_valid, req_pc, resp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_instr, resp_pc, resp_fault, busy
    );

endinterface

// File: rtl/instr_mem_array.sv
// Byte-addressed instruction store with a byte write port and a combinational big-endian word read.
// With INSTR_MEM_PARITY_EN defined each byte also keeps an even-parity bit checked on read.
module instr_mem_array #(
    parameter int ADDR_W     = 14,
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [7:0]              wr_data,
    input  logic [ADDR_W-1:0]       rd_addr,
`ifdef INSTR_MEM_PARITY_EN
    output logic                    rd_par_err,
`endif
    output logic [8*WORD_BYTES-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Byte at rd_addr lands in the MSB; addresses wrap inside the array.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_data[8*(WORD_BYTES-1-i) +: 8] = mem[rd_addr + ADDR_W'(i)];
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par [DEPTH] = '{default: 1'b0};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par[wr_addr] <= ^wr_data;
        end
    end

    always_comb begin
        rd_par_err = 1'b0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if ((^mem[rd_addr + ADDR_W'(i)]) != par[rd_addr + ADDR_W'(i)]) begin
                rd_par_err = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/instr_mem_fetch.sv
// Synchronous instruction memory with valid/ready fetch port, byte loader and fault reporting.
// Optional per-byte parity checking is enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_fetch
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int WORD_BYTES = 4,
    parameter int PC_W       = 32
) (
    input logic               clk,
    input logic               rst_n,
    instr_mem_fetch_if.slave  bus
);

    localparam int OFF_W  = $clog2(WORD_BYTES);
    localparam int WORD_W = 8 * WORD_BYTES;

    state_t state_q;
    state_t state_d;

    logic              accept;
    logic              range_err;
    logic              misalign_err;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] instr_d;
    logic [1:0]        fault_d;

    logic              resp_valid_q;
    logic [WORD_W-1:0] resp_instr_q;
    logic [PC_W-1:0]   resp_pc_q;
    logic [1:0]        resp_fault_q;

`ifdef INSTR_MEM_PARITY_EN
    logic par_err;
`endif

    instr_mem_array #(
        .ADDR_W     (ADDR_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_array (
        .clk        (clk),
        .wr_en      (bus.ld_en),
        .wr_addr    (bus.ld_addr),
        .wr_data    (bus.ld_data),
        .rd_addr    (bus.req_pc[ADDR_W-1:0]),
`ifdef INSTR_MEM_PARITY_EN
        .rd_par_err (par_err),
`endif
        .rd_data    (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A loader strobe always wins: LOAD persists exactly as long as ld_en stays high.
    always_comb begin
        state_d = state_q;
        if (bus.ld_en) begin
            state_d = LOAD;
        end else begin
            state_d = RUN;
        end
    end

    assign bus.req_ready = (state_q == RUN) && !bus.ld_en && (!resp_valid_q || bus.resp_ready);
    assign bus.busy      = (state_q == LOAD);
    assign accept        = bus.req_valid && bus.req_ready;

    assign range_err    = |bus.req_pc[PC_W-1:ADDR_W];
    assign misalign_err = |bus.req_pc[OFF_W-1:0];

    // Faulted fetches still return a response, carrying a NOP so the pipeline stays well-formed.
    always_comb begin
        fault_d = FAULT_OK;
        instr_d = rd_word;
        if (range_err) begin
            fault_d = FAULT_RANGE;
            instr_d = WORD_W'(NOP_WORD);
        end else if (misalign_err) begin
            fault_d = FAULT_MISALIGN;
            instr_d = WORD_W'(NOP_WORD);
        end
`ifdef INSTR_MEM_PARITY_EN
        else if (par_err) begin
            fault_d = FAULT_PARITY;
            instr_d = WORD_W'(NOP_WORD);
        end
`endif
    end

    // Flush beats everything; payload only moves on accept so a stalled response stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_instr_q <= '0;
            resp_pc_q    <= '0;
            resp_fault_q <= FAULT_OK;
        end else if (bus.flush) begin
            resp_valid_q <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_instr_q <= instr_d;
            resp_pc_q    <= bus.req_pc;
            resp_fault_q <= fault_d;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_instr = resp_instr_q;
    assign bus.resp_pc    = resp_pc_q;
    assign bus.resp_fault = resp_fault_q;

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, synchronous successor to the combinational instruction memory.
- Byte-addressed, big-endian array. A 32-bit-wide fetch port uses a valid/ready request/response handshake, so a stalled IF stage can apply backpressure.
- A byte-write loader port programs the array at run time.
- Sits between the PC register and the IF/ID pipeline register. It flags misaligned and out-of-range fetches instead of returning garbage.

Parameters:
- ADDR_W, 14, byte-address bits held in the array; depth = 2**ADDR_W bytes (16384).
- WORD_BYTES, 4, bytes per fetched word; must be a power of two, at least 2.
- PC_W, 32, width of the incoming PC.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted this cycle when high with req_valid.
- req_pc  in  PC_W  byte address of the word to fetch.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_instr  out  8*WORD_BYTES  fetched word; byte at PC is the MSB.
- resp_pc  out  PC_W  PC of the returned word.
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 parity (feature only).
- flush  in  1  discard the pending response (branch redirect).
- ld_en  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader byte address.
- ld_data  in  8  loader byte.
- busy  out  1  high while in LOAD state.

Behaviour:
- Reset values (rst_n low, asynchronous): resp_valid=0, resp_instr=0, resp_pc=0, resp_fault=00, busy=0, state=RUN.
- Array contents are not touched by reset. They are zero at time 0.
- States:
  - RUN: fetches are accepted.
  - LOAD: entered on any cycle with ld_en=1; left to RUN on the first cycle with ld_en=0; busy=1 while in LOAD.
- req_ready = (state==RUN) && !ld_en && (!resp_valid || resp_ready).
  - ld_en has priority: a fetch and a load never complete in the same cycle.
- Loader: ld_en=1 writes ld_data to mem[ld_addr] at the clock edge. The write is visible to a fetch accepted in the following cycle or later.
- Fetch latency is one cycle. On accept at edge N, resp_valid=1 after edge N, and resp_instr/resp_pc/resp_fault are loaded together.
- Data: resp_instr = {mem[a], mem[a+1], …, mem[a+WORD_BYTES-1]} with a = req_pc[ADDR_W-1:0].
- Fault priority: out-of-range over misaligned.
  - Out of range: any bit of req_pc[PC_W-1:ADDR_W] set.
  - Misaligned: req_pc[log2(WORD_BYTES)-1:0] != 0.
  - On any fault, resp_instr=0 (a NOP), and the response is still delivered with valid.
- Holding: while resp_valid=1 and resp_ready=0, all resp_* outputs stay stable.
- A response is consumed when resp_valid && resp_ready. A new accept in the same cycle replaces it back-to-back, giving full throughput of one word per cycle.
- flush=1 forces resp_valid=0 at the next edge and overrides any same-cycle accept.
  - req_ready is unaffected by flush; a request accepted during flush is dropped.
- A loader write to an address whose word is pending in the response register does not alter that response.
- Reset mid-LOAD returns to RUN; bytes already written are kept.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, computed on loader write.
  - On fetch, any byte parity mismatch sets resp_fault=11 and resp_instr=0.
  - Out-of-range and misaligned faults still take priority.
  - Zero-initialised bytes have parity 0, which is consistent.
- Not defined: no parity storage; fault code 11 is never produced.

Decomposition:
- Shared package instr_mem_pkg holds:
  - fault code localparams: FAULT_OK=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10, FAULT_PARITY=2'b11;
  - state encoding RUN/LOAD;
  - NOP word constant 32'h0.
- One sub-module, instr_mem_array: the byte array with its write port, combinational WORD_BYTES-wide big-endian read, and parity storage under the macro.
- The handshake, fault logic and FSM live in the top level.

Test Plan:
- Load 0x24,0x13,0x00,0x05 at 200..203, then fetch pc=200 with resp_ready=1 -> next cycle resp_valid=1, resp_instr=0x24130005, resp_pc=200, resp_fault=00.
- Back-to-back fetches at 200, 204 with resp_ready=1 (word at 204 loaded as 0x24140 00a, i.e. 0x2414000a) -> one response per cycle in order, req_ready held high throughout.
- Hold resp_ready=0 for 3 cycles after a fetch of 200 -> resp_instr stays 0x24130005, req_ready=0, no second accept; release -> drains and accepts the next request.
- Fetch pc=202 -> resp_fault=01, resp_instr=0. Fetch pc=0x00004000 -> resp_fault=10 (range beats misalign at pc=0x00004002).
- Assert ld_en during req_valid -> req_ready=0 and busy=1 the next cycle. Assert flush alongside an accept -> resp_valid=0 afterwards. Pulse rst_n low mid-response -> resp_valid=0 immediately, and memory still reads 0x24130005.
- With INSTR_MEM_PARITY_EN, force-flip a stored parity bit of byte 201 -> fetch 200 returns resp_fault=11, resp_instr=0.
